decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning width of PC and jump-address fields (>=28).
REQ-002 SHALL have parameter DEPTH, default 2, meaning decoded-entry buffer depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  meaning instruction offered.
REQ-006 SHALL have port in_ready  output  1  meaning buffer can accept.
REQ-007 SHALL have port in_instr  input  32  meaning raw instruction word.
REQ-008 SHALL have port in_pc  input  PC_W  meaning address of in_instr.
REQ-009 SHALL have port flush  input  1  meaning discard all buffered entries.
REQ-010 SHALL have port out_valid  output  1  meaning head entry presented.
REQ-011 SHALL have port out_ready  input  1  meaning consumer takes head.
REQ-012 SHALL have ports out_pc PC_W, rs/rt/rd/shamt 5, imm 16, op/funct 6, jaddr PC_W, all outputs, meaning head-entry fields.
REQ-013 SHALL have output alu_ctrl 3 and outputs 1-bit jump, jump_link, jump_reg, branch, bne, mem_write, mem_to_reg, reg_write, reg_dst, alu_imm, illegal, hazard_stall.

Function
REQ-014 Accept SHALL occur on a rising edge with in_valid && in_ready; pop SHALL occur with out_valid && out_ready.
REQ-015 in_ready SHALL equal (count < DEPTH); no same-cycle pass-through when full.
REQ-016 Decode SHALL be computed at accept and stored with the entry; outputs SHALL be driven from the head register only.
REQ-017 Latency: entry accepted at edge N into empty buffer SHALL be visible with out_valid=1 after edge N.
REQ-018 Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
REQ-019 jaddr SHALL equal {(in_pc+4)[PC_W-1:28], instr[25:0], 2'b00}.
REQ-020 Op 0x00 funct 0x20/0x22/0x2A: reg_write, reg_dst; alu_ctrl 000/001/011.
REQ-021 Op 0x00 funct 0x08 (JR): jump, jump_reg; all others 0.
REQ-022 Op 0x23 LW: reg_write, mem_to_reg, alu_imm, alu_ctrl 000; op 0x2B SW: mem_write, alu_imm, alu_ctrl 000.
REQ-023 Op 0x08 ADDI: reg_write, alu_imm, alu_ctrl 000; op 0x0E XORI: same with alu_ctrl 010.
REQ-024 Op 0x04 BEQ: branch, alu_ctrl 001; op 0x05 BNE: branch, bne, alu_ctrl 001.
REQ-025 Op 0x02 J: jump; op 0x03 JAL: jump, jump_link, reg_write.
REQ-026 Any other op/funct: all control bits 0, alu_ctrl 000, illegal=1; entry still flows.
REQ-027 Pointers SHALL wrap modulo DEPTH; simultaneous accept and pop SHALL leave count unchanged.
REQ-028 flush SHALL take priority: count and pointers cleared at edge; concurrent accept/pop discarded.
REQ-029 While out_valid=1 and out_ready=0, all head outputs SHALL hold stable.

Reset
REQ-030 reset=1 SHALL asynchronously clear count, pointers and hazard state; out_valid=0, in_ready=1, all data/control outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; first accept after release behaves as from empty.

Configuration
REQ-032 Macro DECODE_HAZARD_EN SHALL compile in load-use interlock.
REQ-033 With macro: an LW pop with rt!=0 SHALL register ld_rt for exactly one cycle.
REQ-034 With macro: during that cycle, if head rs==ld_rt, or head rt==ld_rt and head is R-type/SW/BEQ/BNE, out_valid SHALL be 0 and hazard_stall 1.
REQ-035 With macro: bubble SHALL last one cycle; ld_rt cleared by flush.
REQ-036 Without macro: hazard_stall tied 0; out_valid=(count!=0).

Verification
REQ-037 Push 0x8D090000 pc 0x00400000 into empty -> next cycle out_valid=1, op 0x23, rs 8, rt 9, reg_write=1, mem_to_reg=1, alu_imm=1.
REQ-038 Push 0x08000010 pc 0x00400000 -> jump=1, jaddr 0x00000040.
REQ-039 out_ready=0, push 3 words with DEPTH=2 -> in_ready=0 after two; third held; pops return first two in order.
REQ-040 Hazard build: pop 0x8D090000 then head 0x01295020 -> one cycle out_valid=0, hazard_stall=1, then add presented (alu_ctrl 000, rd 10).
REQ-041 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, new word not stored.
REQ-042 Push 0xFC000000 -> illegal=1, all control 0; reset mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode buffer: decodes MIPS-style words at accept and queues them for issue.
// Define DECODE_HAZARD_EN to compile in the one-cycle load-use interlock.
module decode_pipe #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [15:0]     imm,
    output logic [5:0]      op,
    output logic [5:0]      funct,
    output logic [PC_W-1:0] jaddr,
    output logic [2:0]      alu_ctrl,
    output logic            jump,
    output logic            jump_link,
    output logic            jump_reg,
    output logic            branch,
    output logic            bne,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            alu_imm,
    output logic            illegal,
    output logic            hazard_stall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [15:0]     imm;
        logic [5:0]      op;
        logic [5:0]      funct;
        logic [PC_W-1:0] jaddr;
        logic [2:0]      alu_ctrl;
        logic            jump;
        logic            jump_link;
        logic            jump_reg;
        logic            branch;
        logic            bne;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            reg_dst;
        logic            alu_imm;
        logic            illegal;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [PC_W-1:0] jaddr_d;
    logic [5:0]      op_d;
    logic [5:0]      fn_d;
    logic            is_r;
    logic            push;
    logic            pop;
    logic            stall;

    // Upper jump bits come from pc+4; only a carry out of [27:2] can change them.
    if (PC_W > 28) begin : g_jhi
        logic [PC_W-29:0] pc_hi;
        assign pc_hi   = in_pc[PC_W-1:28] + (PC_W-28)'(&in_pc[27:2]);
        assign jaddr_d = {pc_hi, in_instr[25:0], 2'b00};
    end else begin : g_jlo
        assign jaddr_d = {in_instr[25:0], 2'b00};
    end

    assign op_d = in_instr[31:26];
    assign fn_d = in_instr[5:0];
    assign is_r = (op_d == 6'h00);

    always_comb begin
        dec       = '0;
        dec.pc    = in_pc;
        dec.op    = op_d;
        dec.rs    = in_instr[25:21];
        dec.rt    = in_instr[20:16];
        dec.rd    = in_instr[15:11];
        dec.shamt = in_instr[10:6];
        dec.funct = fn_d;
        dec.imm   = in_instr[15:0];
        dec.jaddr = jaddr_d;
        unique case (1'b1)
            (is_r && fn_d == 6'h20): begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
            end
            (is_r && fn_d == 6'h22): begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_ctrl  = 3'b001;
            end
            (is_r && fn_d == 6'h2A): begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_ctrl  = 3'b011;
            end
            (is_r && fn_d == 6'h08): begin
                dec.jump     = 1'b1;
                dec.jump_reg = 1'b1;
            end
            (op_d == 6'h23): begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_imm    = 1'b1;
            end
            (op_d == 6'h2B): begin
                dec.mem_write = 1'b1;
                dec.alu_imm   = 1'b1;
            end
            (op_d == 6'h08): begin
                dec.reg_write = 1'b1;
                dec.alu_imm   = 1'b1;
            end
            (op_d == 6'h0E): begin
                dec.reg_write = 1'b1;
                dec.alu_imm   = 1'b1;
                dec.alu_ctrl  = 3'b010;
            end
            (op_d == 6'h04): begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = 3'b001;
            end
            (op_d == 6'h05): begin
                dec.branch   = 1'b1;
                dec.bne      = 1'b1;
                dec.alu_ctrl = 3'b001;
            end
            (op_d == 6'h02): begin
                dec.jump = 1'b1;
            end
            (op_d == 6'h03): begin
                dec.jump      = 1'b1;
                dec.jump_link = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign head      = mem[rd_ptr];
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0) && !stall;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DECODE_HAZARD_EN
    logic       ld_vld;
    logic [4:0] ld_rt;
    logic       uses_rt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_vld <= 1'b0;
            ld_rt  <= '0;
        end else if (flush) begin
            ld_vld <= 1'b0;
            ld_rt  <= '0;
        end else if (pop && head.op == 6'h23 && head.rt != 5'd0) begin
            ld_vld <= 1'b1;
            ld_rt  <= head.rt;
        end else begin
            ld_vld <= 1'b0;
        end
    end

    // rt is a source only for R-type, stores and compares.
    assign uses_rt = (head.op == 6'h00) || (head.op == 6'h2B) ||
                     (head.op == 6'h04) || (head.op == 6'h05);
    assign stall   = ld_vld && (count != '0) &&
                     ((head.rs == ld_rt) || (uses_rt && head.rt == ld_rt));
`else
    assign stall = 1'b0;
`endif

    assign hazard_stall = stall;
    assign out_pc       = head.pc;
    assign rs           = head.rs;
    assign rt           = head.rt;
    assign rd           = head.rd;
    assign shamt        = head.shamt;
    assign imm          = head.imm;
    assign op           = head.op;
    assign funct        = head.funct;
    assign jaddr        = head.jaddr;
    assign alu_ctrl     = head.alu_ctrl;
    assign jump         = head.jump;
    assign jump_link    = head.jump_link;
    assign jump_reg     = head.jump_reg;
    assign branch       = head.branch;
    assign bne          = head.bne;
    assign mem_write    = head.mem_write;
    assign mem_to_reg   = head.mem_to_reg;
    assign reg_write    = head.reg_write;
    assign reg_dst      = head.reg_dst;
    assign alu_imm      = head.alu_imm;
    assign illegal      = head.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode table plus buffer, flush, reset
// and load-use corner sequences.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [5:0]  op, funct;
    logic [31:0] jaddr;
    logic [2:0]  alu_ctrl;
    logic        jump, jump_link, jump_reg, branch, bne;
    logic        mem_write, mem_to_reg, reg_write, reg_dst, alu_imm;
    logic        illegal, hazard_stall;

    logic [10:0] got_flg;
    logic [31:0] got_word;

    int checks = 0;
    int errors = 0;

    decode_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .op(op), .funct(funct), .jaddr(jaddr),
        .alu_ctrl(alu_ctrl), .jump(jump), .jump_link(jump_link),
        .jump_reg(jump_reg), .branch(branch), .bne(bne),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_imm(alu_imm),
        .illegal(illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // Flag order: j jl jr br bne mw m2r rw rd ai ill
    assign got_flg = {jump, jump_link, jump_reg, branch, bne, mem_write,
                      mem_to_reg, reg_write, reg_dst, alu_imm, illegal};
    assign got_word = {op, rs, rt, imm};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  alu;
        logic [10:0] flg;
        logic        chk_j;
        logic [31:0] jad;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    localparam logic [31:0] W_ADD  = 32'h01295020;
    localparam logic [31:0] W_LW   = 32'h8D090000;
    localparam logic [31:0] W_ADDI = 32'h2129FFFF;
    localparam logic [31:0] W_XORI = 32'h392900FF;
    localparam logic [31:0] PC0    = 32'h00400000;

    initial begin
        vt[0]  = '{W_ADD,        PC0, 3'b000, 11'b00000001100, 1'b0, 32'h0};
        vt[1]  = '{32'h01295022, PC0, 3'b001, 11'b00000001100, 1'b0, 32'h0};
        vt[2]  = '{32'h0129502A, PC0, 3'b011, 11'b00000001100, 1'b0, 32'h0};
        vt[3]  = '{32'h01200008, PC0, 3'b000, 11'b10100000000, 1'b0, 32'h0};
        vt[4]  = '{W_LW,         PC0, 3'b000, 11'b00000011010, 1'b0, 32'h0};
        vt[5]  = '{32'hAD090004, PC0, 3'b000, 11'b00000100010, 1'b0, 32'h0};
        vt[6]  = '{W_ADDI,       PC0, 3'b000, 11'b00000001010, 1'b0, 32'h0};
        vt[7]  = '{W_XORI,       PC0, 3'b010, 11'b00000001010, 1'b0, 32'h0};
        vt[8]  = '{32'h11290003, PC0, 3'b001, 11'b00010000000, 1'b0, 32'h0};
        vt[9]  = '{32'h1529FFFE, PC0, 3'b001, 11'b00011000000, 1'b0, 32'h0};
        vt[10] = '{32'h08000010, PC0, 3'b000, 11'b10000000000, 1'b1,
                   32'h00000040};
        vt[11] = '{32'h0C100000, 32'hF0000010, 3'b000, 11'b11000001000,
                   1'b1, 32'hF0400000};
        vt[12] = '{32'h08000001, 32'h0FFFFFFC, 3'b000, 11'b10000000000,
                   1'b1, 32'h10000004};
        vt[13] = '{32'hFC000000, PC0, 3'b000, 11'b00000000001, 1'b0, 32'h0};
        vt[14] = '{32'h01295021, PC0, 3'b000, 11'b00000000001, 1'b0, 32'h0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_flags", 64'({alu_ctrl, got_flg}), 64'd0);
        chk("rst_word", 64'(got_word), 64'd0);
        chk("rst_jaddr", 64'(jaddr), 64'd0);
        chk("rst_stall", 64'(hazard_stall), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Decode table: one entry at a time through an empty buffer.
        for (int i = 0; i < 15; i++) begin
            push(vt[i].instr, vt[i].pc);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_alu", i), 64'(alu_ctrl), 64'(vt[i].alu));
            chk($sformatf("v%0d_flg", i), 64'(got_flg), 64'(vt[i].flg));
            chk($sformatf("v%0d_word", i), 64'(got_word),
                64'(vt[i].instr));
            chk($sformatf("v%0d_rd", i), 64'(rd), 64'(vt[i].instr[15:11]));
            chk($sformatf("v%0d_sh", i), 64'(shamt), 64'(vt[i].instr[10:6]));
            chk($sformatf("v%0d_fn", i), 64'(funct), 64'(vt[i].instr[5:0]));
            chk($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vt[i].pc));
            if (vt[i].chk_j)
                chk($sformatf("v%0d_jaddr", i), 64'(jaddr), 64'(vt[i].jad));
            pop1();
            chk($sformatf("v%0d_empty", i), 64'(out_valid), 64'd0);
        end

        // Fill to DEPTH with consumer stalled; third word must be held off.
        push(W_ADD, PC0);
        push(W_ADDI, PC0 + 4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = W_XORI;
        in_pc    = PC0 + 8;
        @(posedge clk);
        #1;
        chk("full_hold_ready", 64'(in_ready), 64'd0);
        chk("full_hold_head", 64'(got_word), 64'(W_ADD));
        chk("full_hold_pc", 64'(out_pc), 64'(PC0));
        in_valid = 1'b0;
        pop1();
        chk("full_pop1_head", 64'(got_word), 64'(W_ADDI));
        chk("full_pop1_ready", 64'(in_ready), 64'd1);
        pop1();
        chk("full_pop2_empty", 64'(out_valid), 64'd0);

        // Simultaneous accept and pop keeps occupancy at one.
        push(W_ADD, PC0);
        in_valid  = 1'b1;
        in_instr  = W_ADDI;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("sim_head", 64'(got_word), 64'(W_ADDI));
        chk("sim_ready", 64'(in_ready), 64'd1);
        push(W_XORI, PC0);
        chk("sim_full", 64'(in_ready), 64'd0);
        pop1();
        chk("sim_next", 64'(got_word), 64'(W_XORI));
        pop1();
        chk("sim_empty", 64'(out_valid), 64'd0);

        // Flush beats a concurrent accept.
        push(W_ADD, PC0);
        push(W_ADDI, PC0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = W_XORI;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("flush_nostore", 64'(out_valid), 64'd0);
        push(W_XORI, PC0);
        chk("flush_after", 64'(got_word), 64'(W_XORI));
        pop1();

        // Load followed by dependent add.
        push(W_LW, PC0);
        push(W_ADD, PC0 + 4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
`ifdef DECODE_HAZARD_EN
        chk("haz_bubble_valid", 64'(out_valid), 64'd0);
        chk("haz_bubble_stall", 64'(hazard_stall), 64'd1);
        @(posedge clk);
        #1;
`endif
        chk("haz_add_valid", 64'(out_valid), 64'd1);
        chk("haz_add_stall", 64'(hazard_stall), 64'd0);
        chk("haz_add_rd", 64'(rd), 64'd10);
        chk("haz_add_alu", 64'(alu_ctrl), 64'd0);
        chk("haz_add_flg", 64'(got_flg), 64'(11'b00000001100));
        pop1();
        chk("haz_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset in mid-stream.
        push(32'hFC000000, PC0);
        push(W_ADD, PC0);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_ill", 64'(illegal), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(W_XORI, PC0);
        chk("mrst_first", 64'(got_word), 64'(W_XORI));
        chk("mrst_first_v", 64'(out_valid), 64'd1);
        chk("mrst_first_rdy", 64'(in_ready), 64'd1);
        pop1();
        chk("mrst_empty", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
